pe_seq: RTL

PE_SEQ -- requirements
Module: pe_seq

---
 rtl/pe_seq.sv | 92 +++++++++
 1 files changed

// File: rtl/pe_seq.sv
// pe_seq: sequential processing element with four neighbour operands, three local registers, a memory word and a restoring divider
module pe_seq #(
    parameter int DATA_W = 8,
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              ctrl_valid,
    output logic              ctrl_ready,
    input  logic [DATA_W-1:0] E,
    input  logic [DATA_W-1:0] S,
    input  logic [DATA_W-1:0] W,
    input  logic [DATA_W-1:0] N,
    output logic [DATA_W-1:0] OutputE,
    output logic [DATA_W-1:0] OutputS,
    output logic [DATA_W-1:0] OutputW,
    output logic [DATA_W-1:0] OutputN,
    output logic [DATA_W-1:0] Data_memory,
    output logic              done,
    output logic              div_err
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    typedef enum logic [1:0] {IDLE, EXEC, DIV, WB} state_t;
    state_t state, state_nx;
    logic [7:0][DATA_W-1:0] dst_q;
    logic [7:0][DATA_W-1:0] src;
    logic [2:0] op, dst;
    logic [DATA_W-1:0] a, b, rem, rem_nx, alu, wr_val;
    logic [DATA_W:0] rem_sh, diff;
    logic [CNT_W-1:0] cnt;
    logic wr_en, wr_err, ge;
    assign src = {dst_q[7:4], N, W, S, E};
    assign {Data_memory, OutputN, OutputW, OutputS, OutputE} = {dst_q[7], dst_q[3], dst_q[2], dst_q[1], dst_q[0]};
    assign ctrl_ready = state == IDLE;
    assign alu = op == 3'd0 ? a + b : op == 3'd1 ? a - b : op == 3'd2 ? a * b :
                 op == 3'd4 ? a & b : op == 3'd5 ? a | b : op == 3'd6 ? a ^ b : a;
    assign rem_sh = {rem, a[DATA_W-1]};
    assign diff = rem_sh - {1'b0, b};
    assign ge = ~diff[DATA_W];
    assign rem_nx = ge ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    // next state and write strobe; a zero divisor forces an all-ones result
    always_comb begin
        state_nx = state;
        wr_en = 1'b0;
        wr_err = 1'b0;
        wr_val = alu;
        case (state)
            IDLE: if (ctrl_valid) state_nx = ctrl[2:0] == 3'd3 ? DIV : EXEC;
            EXEC: begin
                state_nx = IDLE;
                wr_en = 1'b1;
            end
            DIV: if (cnt == CNT_W'(DATA_W - 1)) state_nx = WB;
            WB: begin
                state_nx = IDLE;
                wr_en = 1'b1;
                wr_err = b == '0;
                wr_val = b == '0 ? '1 : a;
            end
            default: state_nx = IDLE;
        endcase
    end
    // snapshot instruction and operands on accept; during DIV shift the quotient into a
    always_ff @(posedge clk) begin
        if (state == IDLE && ctrl_valid) begin
            op <= ctrl[2:0];
            dst <= ctrl[11:9];
            a <= src[ctrl[8:6]];
            b <= src[ctrl[5:3]];
            rem <= '0;
            cnt <= '0;
        end else if (state == DIV) begin
            a <= {a[DATA_W-2:0], ge};
            rem <= rem_nx;
            cnt <= cnt + 1'b1;
        end
    end
    // destination file: exactly one entry written per instruction
    always_ff @(posedge clk) begin
        if (rst) dst_q <= '0;
        else if (wr_en) dst_q[dst] <= wr_val;
    end
    // completion pulses follow the write edge
    always_ff @(posedge clk) begin
        done <= ~rst & wr_en;
        div_err <= ~rst & wr_en & wr_err;
    end
endmodule
